grid_tile_arbiter: RTL and testbench



---
 rtl/grid_tile_arbiter.sv | 135 +++++++++++++
 tb/tb_grid_tile_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_tile_arbiter.sv
// Maze-tile colour memory for the VGA path: round-robin write arbitration between
// the radio (A) and debug (B) requesters, vblank-only writes, clear sweeps, pixel lookup.
module grid_tile_arbiter #(
  parameter int unsigned GRID_W      = 4,
  parameter int unsigned GRID_H      = 5,
  parameter int unsigned TILE_PX     = 100,
  parameter int unsigned V_VISIBLE   = 480,
  parameter logic [7:0]  CLEAR_COLOR = 8'h00,
  parameter logic [7:0]  BG_COLOR    = 8'h00
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic [9:0] PIXEL_X,
  input  logic [9:0] PIXEL_Y,
  output logic [7:0] PIXEL_COLOR,
  input  logic       A_VALID,
  output logic       A_READY,
  input  logic [2:0] A_TILE_X,
  input  logic [2:0] A_TILE_Y,
  input  logic [7:0] A_COLOR,
  input  logic       B_VALID,
  output logic       B_READY,
  input  logic [2:0] B_TILE_X,
  input  logic [2:0] B_TILE_Y,
  input  logic [7:0] B_COLOR,
  input  logic       CLEAR,
  output logic       BUSY,
  output logic       BAD_WR
);

  localparam int unsigned N_TILES = GRID_W * GRID_H;
  localparam int unsigned IDX_W   = (N_TILES > 1) ? $clog2(N_TILES) : 1;

  localparam logic [0:0] ST_SWEEP = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  logic [7:0]       mem [N_TILES];
  logic [0:0]       state;
  logic [IDX_W-1:0] sweep_idx;
  logic             prefer_b;

  logic             vblank;
  logic             open_grant;
  logic             a_xfer;
  logic             b_xfer;
  logic             wr_bad;
  logic             wr_en;
  logic [2:0]       wr_x;
  logic [2:0]       wr_y;
  logic [7:0]       wr_color;
  logic [IDX_W-1:0] wr_lin;

  logic [9:0]       tx;
  logic [9:0]       ty;
  logic             pix_in;
  logic [IDX_W-1:0] rd_lin;

  always_comb begin
    vblank     = PIXEL_Y >= 10'(V_VISIBLE);
    BUSY       = (state == ST_SWEEP);
    // CLEAR outranks any pending request in the cycle it is seen
    open_grant = (state == ST_IDLE) && !CLEAR && vblank;
    A_READY    = open_grant && A_VALID && (!B_VALID || !prefer_b);
    B_READY    = open_grant && B_VALID && (!A_VALID || prefer_b);
    a_xfer     = A_VALID && A_READY;
    b_xfer     = B_VALID && B_READY;

    wr_x     = A_TILE_X;
    wr_y     = A_TILE_Y;
    wr_color = A_COLOR;
    if (b_xfer) begin
      wr_x     = B_TILE_X;
      wr_y     = B_TILE_Y;
      wr_color = B_COLOR;
    end
    wr_bad = (32'(wr_x) >= GRID_W) || (32'(wr_y) >= GRID_H);
    wr_en  = (a_xfer || b_xfer) && !wr_bad;
    wr_lin = IDX_W'(wr_y) * IDX_W'(GRID_W) + IDX_W'(wr_x);
  end

  always_comb begin
    tx     = PIXEL_X / 10'(TILE_PX);
    ty     = PIXEL_Y / 10'(TILE_PX);
    pix_in = (32'(tx) < GRID_W) && (32'(ty) < GRID_H);
    rd_lin = IDX_W'(ty) * IDX_W'(GRID_W) + IDX_W'(tx);
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      if (state == ST_SWEEP) begin
        mem[sweep_idx] <= CLEAR_COLOR;
      end else if (wr_en) begin
        mem[wr_lin] <= wr_color;
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state       <= ST_SWEEP;
      sweep_idx   <= '0;
      prefer_b    <= 1'b0;
      PIXEL_COLOR <= '0;
      BAD_WR      <= 1'b0;
    end else begin
      case (state)
        ST_SWEEP: begin
          if (sweep_idx == IDX_W'(N_TILES - 1)) begin
            state     <= ST_IDLE;
            sweep_idx <= '0;
          end else begin
            sweep_idx <= sweep_idx + IDX_W'(1);
          end
        end
        default: begin
          if (CLEAR) begin
            state     <= ST_SWEEP;
            sweep_idx <= '0;
          end
        end
      endcase

      if (a_xfer) begin
        prefer_b <= 1'b1;
      end else if (b_xfer) begin
        prefer_b <= 1'b0;
      end

      BAD_WR <= (a_xfer || b_xfer) && wr_bad;
      // Nonblocking read: a same-cycle write to this entry shows up on the next lookup
      PIXEL_COLOR <= pix_in ? mem[rd_lin] : BG_COLOR;
    end
  end

endmodule

// File: tb/tb_grid_tile_arbiter.sv
// Directed bench for grid_tile_arbiter: vector table for arbitration plus
// hand sequences for sweeps, stalls, clear priority and mid-sweep reset.
module tb_grid_tile_arbiter;

  logic       CLOCK;
  logic       RESET;
  logic [9:0] PIXEL_X;
  logic [9:0] PIXEL_Y;
  logic [7:0] PIXEL_COLOR;
  logic       A_VALID;
  logic       A_READY;
  logic [2:0] A_TILE_X;
  logic [2:0] A_TILE_Y;
  logic [7:0] A_COLOR;
  logic       B_VALID;
  logic       B_READY;
  logic [2:0] B_TILE_X;
  logic [2:0] B_TILE_Y;
  logic [7:0] B_COLOR;
  logic       CLEAR;
  logic       BUSY;
  logic       BAD_WR;

  int checks = 0;
  int errors = 0;

  grid_tile_arbiter #(
    .GRID_W(4), .GRID_H(5), .TILE_PX(100), .V_VISIBLE(480),
    .CLEAR_COLOR(8'h00), .BG_COLOR(8'h00)
  ) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .PIXEL_X(PIXEL_X), .PIXEL_Y(PIXEL_Y), .PIXEL_COLOR(PIXEL_COLOR),
    .A_VALID(A_VALID), .A_READY(A_READY), .A_TILE_X(A_TILE_X),
    .A_TILE_Y(A_TILE_Y), .A_COLOR(A_COLOR),
    .B_VALID(B_VALID), .B_READY(B_READY), .B_TILE_X(B_TILE_X),
    .B_TILE_Y(B_TILE_Y), .B_COLOR(B_COLOR),
    .CLEAR(CLEAR), .BUSY(BUSY), .BAD_WR(BAD_WR)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic       a_v;
    logic [2:0] a_x;
    logic [2:0] a_y;
    logic [7:0] a_c;
    logic       b_v;
    logic [2:0] b_x;
    logic [2:0] b_y;
    logic [7:0] b_c;
    logic [9:0] py;
    logic       e_ar;
    logic       e_br;
    logic       e_bad;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic read_pix(input string name, input logic [9:0] x, input logic [9:0] y,
                          input logic [7:0] exp);
    PIXEL_X = x;
    PIXEL_Y = y;
    step();
    chk(name, PIXEL_COLOR, exp);
  endtask

  // Counts BUSY cycles from the current sample point; bounded so a stuck sweep still ends.
  task automatic count_busy(output int n, output logic rdy_seen);
    n = 0;
    rdy_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!BUSY) break;
      n++;
      if (A_READY || B_READY) rdy_seen = 1'b1;
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic rdy;

    tbl[0]  = '{1'b1, 3'd0, 3'd0, 8'h11, 1'b1, 3'd1, 3'd0, 8'h22, 10'd480, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 3'd0, 3'd0, 8'h33, 1'b1, 3'd1, 3'd0, 8'h22, 10'd480, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 3'd0, 3'd0, 8'h33, 1'b1, 3'd1, 3'd0, 8'h44, 10'd480, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 3'd3, 3'd4, 8'h5A, 1'b1, 3'd1, 3'd0, 8'h44, 10'd480, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 3'd3, 3'd4, 8'h5A, 1'b0, 3'd0, 3'd0, 8'h00, 10'd480, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 3'd0, 3'd0, 8'h00, 1'b1, 3'd2, 3'd0, 8'h66, 10'd480, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 3'd3, 3'd0, 8'h77, 1'b0, 3'd0, 3'd0, 8'h00, 10'd480, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 3'd0, 3'd1, 8'h99, 1'b1, 3'd2, 3'd1, 8'h88, 10'd479, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 3'd0, 3'd1, 8'h99, 1'b1, 3'd2, 3'd1, 8'h88, 10'd480, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 3'd0, 3'd1, 8'h99, 1'b1, 3'd4, 3'd0, 8'hE0, 10'd480, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 3'd0, 3'd0, 8'h00, 1'b1, 3'd4, 3'd0, 8'hE0, 10'd480, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 3'd0, 3'd5, 8'hC3, 1'b0, 3'd0, 3'd0, 8'h00, 10'd480, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 3'd0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 8'h00, 10'd480, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 3'd0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 8'h00, 10'd480, 1'b0, 1'b0, 1'b0};

    // Reset with both requesters pending in vblank: nothing may be granted during the sweep
    RESET = 1'b1; CLEAR = 1'b0;
    PIXEL_X = '0; PIXEL_Y = 10'd480;
    A_VALID = 1'b1; A_TILE_X = 3'd0; A_TILE_Y = 3'd0; A_COLOR = 8'hAA;
    B_VALID = 1'b1; B_TILE_X = 3'd1; B_TILE_Y = 3'd0; B_COLOR = 8'hBB;
    step();
    chk("reset BUSY", BUSY, 1'b1);
    chk("reset A_READY", A_READY, 1'b0);
    chk("reset B_READY", B_READY, 1'b0);
    chk("reset PIXEL_COLOR", PIXEL_COLOR, 8'h00);
    chk("reset BAD_WR", BAD_WR, 1'b0);
    RESET = 1'b0;
    count_busy(n, rdy);
    A_VALID = 1'b0;
    B_VALID = 1'b0;
    chk("reset sweep length", n, 20);
    chk("ready during reset sweep", rdy, 1'b0);
    for (int ty = 0; ty < 5; ty++) begin
      for (int tx = 0; tx < 4; tx++) begin
        read_pix($sformatf("cleared tile %0d,%0d", tx, ty),
                 10'(tx * 100 + 50), 10'(ty * 100 + 50), 8'h00);
      end
    end

    // Arbitration table: contention, single requester, active-video stall, out of range
    for (int i = 0; i < 14; i++) begin
      A_VALID = tbl[i].a_v; A_TILE_X = tbl[i].a_x; A_TILE_Y = tbl[i].a_y; A_COLOR = tbl[i].a_c;
      B_VALID = tbl[i].b_v; B_TILE_X = tbl[i].b_x; B_TILE_Y = tbl[i].b_y; B_COLOR = tbl[i].b_c;
      PIXEL_X = '0;
      PIXEL_Y = tbl[i].py;
      #1;
      chk($sformatf("vec%0d A_READY", i), A_READY, tbl[i].e_ar);
      chk($sformatf("vec%0d B_READY", i), B_READY, tbl[i].e_br);
      chk($sformatf("vec%0d BAD_WR", i), BAD_WR, tbl[i].e_bad);
      chk($sformatf("vec%0d BUSY", i), BUSY, 1'b0);
      step();
    end
    A_VALID = 1'b0;
    B_VALID = 1'b0;
    read_pix("tile 0,0 after E0 to x=4", 10'd10, 10'd10, 8'h33);
    read_pix("tile 1,0", 10'd150, 10'd10, 8'h44);
    read_pix("tile 2,0", 10'd250, 10'd10, 8'h66);
    read_pix("tile 3,0", 10'd350, 10'd10, 8'h77);
    read_pix("tile 0,1 not aliased", 10'd50, 10'd150, 8'h99);
    read_pix("tile 2,1", 10'd250, 10'd150, 8'h88);
    read_pix("tile 3,4", 10'd350, 10'd450, 8'h5A);

    // Write stalled by active video until PIXEL_Y reaches 480
    A_VALID = 1'b1; A_TILE_X = 3'd1; A_TILE_Y = 3'd2; A_COLOR = 8'h1C;
    PIXEL_X = 10'd0;
    PIXEL_Y = 10'd100; #1; chk("stall y=100", A_READY, 1'b0); step();
    PIXEL_Y = 10'd300; #1; chk("stall y=300", A_READY, 1'b0); step();
    PIXEL_Y = 10'd479; #1; chk("stall y=479", A_READY, 1'b0); step();
    PIXEL_Y = 10'd480; #1; chk("grant y=480", A_READY, 1'b1); step();
    A_VALID = 1'b0;
    #1;
    chk("ready drops after transfer", A_READY, 1'b0);
    chk("in-range write no BAD_WR", BAD_WR, 1'b0);
    read_pix("stalled write visible", 10'd150, 10'd250, 8'h1C);

    // Same-cycle write and lookup of tile (0,4): old value first, new value next
    PIXEL_X = 10'd10; PIXEL_Y = 10'd485;
    B_VALID = 1'b1; B_TILE_X = 3'd0; B_TILE_Y = 3'd4; B_COLOR = 8'h55;
    #1;
    chk("same-cycle B_READY", B_READY, 1'b1);
    step();
    B_VALID = 1'b0;
    chk("same-cycle read old", PIXEL_COLOR, 8'h00);
    step();
    chk("same-cycle read new", PIXEL_COLOR, 8'h55);

    // Background and grid edges
    read_pix("bg 450,100", 10'd450, 10'd100, 8'h00);
    read_pix("bg 400,0", 10'd400, 10'd0, 8'h00);
    read_pix("bg 0,500", 10'd0, 10'd500, 8'h00);
    read_pix("edge 399,499", 10'd399, 10'd499, 8'h5A);

    // CLEAR beats a pending write; write lands after the sweep
    PIXEL_X = 10'd0; PIXEL_Y = 10'd480;
    CLEAR = 1'b1;
    A_VALID = 1'b1; A_TILE_X = 3'd2; A_TILE_Y = 3'd2; A_COLOR = 8'h3F;
    #1;
    chk("clear blocks A_READY", A_READY, 1'b0);
    chk("clear cycle BUSY", BUSY, 1'b0);
    step();
    CLEAR = 1'b0;
    count_busy(n, rdy);
    chk("clear sweep length", n, 20);
    chk("ready during clear sweep", rdy, 1'b0);
    chk("A_READY after sweep", A_READY, 1'b1);
    step();
    A_VALID = 1'b0;
    read_pix("post-clear write survives", 10'd250, 10'd250, 8'h3F);
    read_pix("post-clear 1,2 cleared", 10'd150, 10'd250, 8'h00);
    read_pix("post-clear 0,0 cleared", 10'd10, 10'd10, 8'h00);

    // Reset at sweep index 7 restarts the sweep and the round-robin pointer
    PIXEL_Y = 10'd0;
    CLEAR = 1'b1;
    step();
    CLEAR = 1'b0;
    repeat (7) step();
    chk("mid-sweep BUSY", BUSY, 1'b1);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    count_busy(n, rdy);
    chk("restarted sweep length", n, 20);
    PIXEL_Y = 10'd480;
    A_VALID = 1'b1; A_TILE_X = 3'd0; A_TILE_Y = 3'd0;
    B_VALID = 1'b1; B_TILE_X = 3'd1; B_TILE_Y = 3'd0;
    #1;
    chk("post-reset contention A", A_READY, 1'b1);
    chk("post-reset contention B", B_READY, 1'b0);
    A_VALID = 1'b0;
    B_VALID = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
